// File: rtl/sample_voice_mixer.sv
// Multi-voice sample player: once per I2S frame, reads one byte per active
// voice from SPI flash and sums all voices (inactive voices count as silence).
module sample_voice_mixer #(
    parameter int unsigned        NUM_VOICES   = 4,
    parameter int unsigned        ADDR_W       = 24,
    parameter logic [ADDR_W-1:0]  BASE_ADDR    = 24'h000000,
    parameter logic [ADDR_W-1:0]  VOICE_STRIDE = 24'h010000,
    parameter int unsigned        SAMPLE_LEN   = 16000,
    localparam int unsigned       VID_W        = $clog2(NUM_VOICES),
    localparam int unsigned       POS_W        = $clog2(SAMPLE_LEN),
    localparam int unsigned       OUT_W        = 8 + VID_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lrclk,
    input  logic                  trig_valid,
    input  logic [VID_W-1:0]      trig_voice,
    input  logic                  trig_loop,
    input  logic                  trig_stop,
    output logic                  spi_start_read,
    output logic [ADDR_W-1:0]     spi_addr,
    input  logic                  spi_data_ready,
    input  logic [7:0]            spi_data,
    output logic [OUT_W-1:0]      sample_data,
    output logic                  sample_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  overrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_APPLY, S_SELECT, S_ISSUE, S_WAIT, S_DONE
    } state_t;

    localparam logic [VID_W-1:0] LAST_VID  = VID_W'(NUM_VOICES - 1);
    localparam logic [POS_W-1:0] LAST_POS  = POS_W'(SAMPLE_LEN - 1);
    localparam logic [OUT_W-1:0] SILENCE   = OUT_W'(128);
    localparam logic [OUT_W-1:0] RESET_MIX = OUT_W'(NUM_VOICES * 128);

    state_t state_q, state_d;

    logic                              lrclk_q;
    logic                              frame_start_c;
    logic [NUM_VOICES-1:0]             pend_start_q, pend_start_d;
    logic [NUM_VOICES-1:0]             pend_loop_q,  pend_loop_d;
    logic [NUM_VOICES-1:0]             pend_stop_q,  pend_stop_d;
    logic [NUM_VOICES-1:0]             active_q,     active_d;
    logic [NUM_VOICES-1:0]             loop_q,       loop_d;
    logic [NUM_VOICES-1:0][POS_W-1:0]  pos_q,        pos_d;
    logic [OUT_W-1:0]                  acc_q,        acc_d;
    logic [VID_W-1:0]                  idx_q,        idx_d;
    logic                              start_d;
    logic [ADDR_W-1:0]                 addr_d;
    logic [OUT_W-1:0]                  sample_d;
    logic                              valid_d;
    logic                              overrun_d;

    assign frame_start_c = ~lrclk_q & lrclk;
    assign voice_active  = active_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: walk every voice once per frame, one SPI read at a time
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (frame_start_c) state_d = S_APPLY;
            S_APPLY:  state_d = S_SELECT;
            S_SELECT: begin
                if (active_q[idx_q])        state_d = S_ISSUE;
                else if (idx_q == LAST_VID) state_d = S_DONE;
            end
            S_ISSUE:  state_d = S_WAIT;
            S_WAIT: begin
                if (spi_data_ready) state_d = (idx_q == LAST_VID) ? S_DONE : S_SELECT;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pend_start_d = pend_start_q;
        pend_loop_d  = pend_loop_q;
        pend_stop_d  = pend_stop_q;
        active_d     = active_q;
        loop_d       = loop_q;
        pos_d        = pos_q;
        acc_d        = acc_q;
        idx_d        = idx_q;
        start_d      = 1'b0;
        addr_d       = spi_addr;
        sample_d     = sample_data;
        valid_d      = 1'b0;
        overrun_d    = overrun | (frame_start_c && (state_q != S_IDLE));

        case (state_q)
            S_APPLY: begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (pend_start_q[v]) begin
                        active_d[v] = 1'b1;
                        pos_d[v]    = '0;
                        loop_d[v]   = pend_loop_q[v];
                    end else if (pend_stop_q[v]) begin
                        active_d[v] = 1'b0;
                    end
                end
                pend_start_d = '0;
                pend_loop_d  = '0;
                pend_stop_d  = '0;
                acc_d        = '0;
                idx_d        = '0;
            end
            S_SELECT: begin
                if (!active_q[idx_q]) begin
                    acc_d = acc_q + SILENCE;
                    if (idx_q != LAST_VID) idx_d = idx_q + VID_W'(1);
                end
            end
            S_WAIT: begin
                if (spi_data_ready) begin
                    acc_d        = acc_q + OUT_W'(spi_data);
                    pos_d[idx_q] = pos_q[idx_q] + POS_W'(1);
                    if (pos_q[idx_q] == LAST_POS) begin
                        pos_d[idx_q] = '0;
                        if (!loop_q[idx_q]) active_d[idx_q] = 1'b0;
                    end
                    if (idx_q != LAST_VID) idx_d = idx_q + VID_W'(1);
                end
            end
            S_DONE: begin
                sample_d = acc_q;
                valid_d  = 1'b1;
            end
            default: ;
        endcase

        // Read request is high exactly while in ISSUE; address held until the next request
        if (state_d == S_ISSUE) begin
            start_d = 1'b1;
            addr_d  = BASE_ADDR + ADDR_W'(idx_q) * VOICE_STRIDE + ADDR_W'(pos_q[idx_q]);
        end

        // Commands latch last so one arriving during APPLY survives the clear
        if (trig_valid) begin
            if (trig_stop) begin
                pend_stop_d[trig_voice]  = 1'b1;
                pend_start_d[trig_voice] = 1'b0;
            end else begin
                pend_start_d[trig_voice] = 1'b1;
                pend_stop_d[trig_voice]  = 1'b0;
                pend_loop_d[trig_voice]  = trig_loop;
            end
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            lrclk_q        <= 1'b0;
            pend_start_q   <= '0;
            pend_loop_q    <= '0;
            pend_stop_q    <= '0;
            active_q       <= '0;
            loop_q         <= '0;
            pos_q          <= '0;
            acc_q          <= '0;
            idx_q          <= '0;
            spi_start_read <= 1'b0;
            spi_addr       <= '0;
            sample_data    <= RESET_MIX;
            sample_valid   <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            lrclk_q        <= lrclk;
            pend_start_q   <= pend_start_d;
            pend_loop_q    <= pend_loop_d;
            pend_stop_q    <= pend_stop_d;
            active_q       <= active_d;
            loop_q         <= loop_d;
            pos_q          <= pos_d;
            acc_q          <= acc_d;
            idx_q          <= idx_d;
            spi_start_read <= start_d;
            spi_addr       <= addr_d;
            sample_data    <= sample_d;
            sample_valid   <= valid_d;
            overrun        <= overrun_d;
        end
    end

endmodule
